// File: rtl/mod12289s_mac_pkg.sv
// Shared constants for the mod-12289 signed multiply-accumulate block.
// Every derived value below follows from the modulus.
package mod12289s_mac_pkg;

    localparam int MOD_Q = 12289;
    localparam int HALF  = MOD_Q / 2;
    localparam int W_Z   = 14;
    localparam int W_S   = 27;
    localparam int II    = 5;

    localparam int W_X   = W_S + 1;
    localparam int W_P   = 2 * W_X;
    localparam int W_QT  = 16;

    // Rounded reciprocal for the reducer's quotient estimate
    localparam int BAR_K = 40;
    localparam longint BAR_M_L =
        ((64'sd1 <<< BAR_K) + longint'(MOD_Q / 2)) / longint'(MOD_Q);
    localparam logic signed [W_X-1:0] BAR_M = W_X'(BAR_M_L);

endpackage

// File: rtl/mod12289s_mac_if.sv
// Operand/result bundle for the MAC: valid/ready input side plus
// a one-cycle result pulse.
interface mod12289s_mac_if;
    import mod12289s_mac_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic                  in_first;
    logic                  in_last;
    logic signed [W_Z-1:0] inA;
    logic signed [W_Z-1:0] inB;
    logic                  out_valid;
    logic signed [W_Z-1:0] outZ;

    modport master (
        output in_valid, in_first, in_last, inA, inB,
        input  in_ready, out_valid, outZ
    );

    modport slave (
        input  in_valid, in_first, in_last, inA, inB,
        output in_ready, out_valid, outZ
    );

endinterface

// File: rtl/mod12289s.sv
// Three-stage signed reducer: 27-bit value to a 14-bit residue
// in [-6144, 6145], congruent mod 12289.
module mod12289s
    import mod12289s_mac_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic signed [W_S-1:0] inZ,
    output logic signed [W_Z-1:0] outZ
);

    logic signed [W_X-1:0]  w_x;
    logic signed [W_P-1:0]  w_p;
    logic signed [W_QT-1:0] w_q;
    logic signed [W_X-1:0]  w_qq;
    logic signed [W_X-1:0]  w_r;

    logic signed [W_X-1:0]  r_x1;
    logic signed [W_P-1:0]  r_p1;
    logic signed [W_X-1:0]  r_x2;
    logic signed [W_X-1:0]  r_qq2;
    logic signed [W_Z-1:0]  r_z;

    // Offset by HALF so the floor quotient lands the remainder in
    // [0, Q]; removing the offset afterwards nearly centers it.
    assign w_x  = W_X'(inZ) + W_X'(HALF);
    assign w_p  = W_P'(w_x) * W_P'(BAR_M);
    assign w_q  = W_QT'(r_p1 >>> BAR_K);
    assign w_qq = W_X'(w_q) * W_X'(MOD_Q);
    assign w_r  = r_x2 - r_qq2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x1  <= '0;
            r_p1  <= '0;
            r_x2  <= '0;
            r_qq2 <= '0;
            r_z   <= '0;
        end else begin
            r_x1  <= w_x;
            r_p1  <= w_p;
            r_x2  <= r_x1;
            r_qq2 <= w_qq;
            r_z   <= W_Z'(w_r - W_X'(HALF));
        end
    end

    assign outZ = r_z;

endmodule

// File: rtl/mod12289s_mac.sv
// Signed dot-product MAC mod 12289, one pair every five cycles,
// centered accumulator held between frames.
module mod12289s_mac
    import mod12289s_mac_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    mod12289s_mac_if.slave s
);

    localparam logic [3:0] CNT_INIT = 4'(II - 1);

    logic [3:0]            r_cnt;
    logic signed [W_S-1:0] r_s1;
    logic                  r_last;
    logic                  r_out_valid;
    logic signed [W_Z-1:0] r_acc;

    logic                    w_accept;
    logic                    w_rst_h;
    logic signed [2*W_Z-1:0] w_prod;
    logic signed [W_S-1:0]   w_addend;
    logic signed [W_S-1:0]   w_s1;
    logic signed [W_Z-1:0]   w_red;
    logic signed [W_Z-1:0]   w_cor;

    assign s.in_ready = (r_cnt == 4'd0);
    assign w_accept   = s.in_valid && s.in_ready;
    assign w_rst_h    = ~rst;

    assign w_prod   = (2*W_Z)'(s.inA) * (2*W_Z)'(s.inB);
    assign w_addend = s.in_first ? '0
                    : {{(W_S-W_Z){r_acc[W_Z-1]}}, r_acc};
    assign w_s1     = W_S'(w_prod) + w_addend;

    mod12289s u_red (
        .clk  (clk),
        .rst  (w_rst_h),
        .inZ  (r_s1),
        .outZ (w_red)
    );

    always_comb begin
        w_cor = w_red;
        if (w_red > W_Z'(HALF))
            w_cor = W_Z'(int'(w_red) - MOD_Q);
        else if (w_red < W_Z'(-HALF))
            w_cor = W_Z'(int'(w_red) + MOD_Q);
    end

    // S1 stays put until the next acceptance so the reducer output
    // is stable when the countdown reaches one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_s1        <= '0;
            r_last      <= 1'b0;
            r_out_valid <= 1'b0;
            r_acc       <= '0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_accept) begin
                r_cnt  <= CNT_INIT;
                r_s1   <= w_s1;
                r_last <= s.in_last;
            end else if (r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    r_acc       <= w_cor;
                    r_out_valid <= r_last;
                end
            end
        end
    end

    assign s.out_valid = r_out_valid;
    assign s.outZ      = r_acc;

endmodule

// File: tb/tb_mod12289s_mac.sv
// Bench for mod12289s_mac: vector table, handshake/reset sequences,
// and random frames against an arithmetic modular model.
module tb_mod12289s_mac;

    localparam int Q       = 12289;
    localparam int NFRAMES = 600;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mod12289s_mac_if bus();

    mod12289s_mac dut (
        .clk (clk),
        .rst (rst),
        .s   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int a;
        int b;
        bit first;
        bit last;
        bit ov;
        int z;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int cmod(input longint x);
        longint r;
        r = x % longint'(Q);
        if (r < 0) r = r + Q;
        if (r > Q / 2) r = r - Q;
        return int'(r);
    endfunction

    function automatic int rnd_op();
        int sel;
        sel = int'($urandom_range(0, 7));
        if (sel == 0) return 6144;
        if (sel == 1) return -6144;
        return int'($urandom_range(0, 12288)) - 6144;
    endfunction

    function automatic vec_t mk(input int a, input int b, input bit f,
                                input bit l, input bit ov, input int z);
        vec_t v;
        v.a = a; v.b = b; v.first = f; v.last = l; v.ov = ov; v.z = z;
        return v;
    endfunction

    // One pair: accept, then sample the four cycles up to completion.
    // bad counts cycles where out_valid/in_ready deviate from timing.
    task automatic do_pair(input int a, input int b, input bit f,
                           input bit l, input int gap, output bit ov,
                           output int z, output int bad);
        int w;
        repeat (gap) @(posedge clk);
        @(negedge clk);
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before_pair", int'(bus.in_ready === 1'b1), 1);
        bus.inA      = 14'(a);
        bus.inB      = 14'(b);
        bus.in_first = f;
        bus.in_last  = l;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        bad = 0;
        ov  = 1'b0;
        z   = 0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            if (i < 4) begin
                bad = bad + int'(bus.out_valid === 1'b1);
                bad = bad + int'(bus.in_ready === 1'b1);
            end else begin
                ov  = bus.out_valid;
                z   = int'(bus.outZ);
                bad = bad + int'(bus.in_ready !== 1'b1);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit     ov;
        int     z;
        int     bad;
        int     pat;
        int     exp_pat;
        int     acc_n;
        int     pulses;
        longint sum;

        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
        bus.inA      = '0;
        bus.inB      = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", int'(bus.in_ready), 1);
        chk("reset_out_valid", int'(bus.out_valid), 0);
        chk("reset_outZ", int'(bus.outZ), 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_in_ready", int'(bus.in_ready), 1);

        tbl.push_back(mk( 6144,  6144, 1, 1, 1, -3072));
        tbl.push_back(mk(   -1,     1, 1, 1, 1,    -1));
        tbl.push_back(mk(-6144,  6144, 1, 1, 1,  3072));
        tbl.push_back(mk(    1,     1, 1, 0, 0,     1));
        tbl.push_back(mk(    2,     3, 0, 0, 0,     7));
        tbl.push_back(mk(  100,   100, 0, 1, 1, -2282));
        tbl.push_back(mk(    3,     4, 1, 1, 1,    12));
        tbl.push_back(mk(    1,     1, 0, 1, 1,    13));
        tbl.push_back(mk(    2,     2, 1, 1, 1,     4));
        tbl.push_back(mk( 6144,     1, 1, 1, 1,  6144));
        tbl.push_back(mk(-6144,     1, 1, 1, 1, -6144));
        tbl.push_back(mk(-6144, -6144, 1, 1, 1, -3072));
        tbl.push_back(mk(    0,     0, 1, 1, 1,     0));
        tbl.push_back(mk( 6144,  6144, 1, 0, 0, -3072));
        tbl.push_back(mk( 6144,  6144, 0, 0, 0, -6144));
        tbl.push_back(mk( 6144,  6144, 0, 1, 1,  3073));
        tbl.push_back(mk( 6144,     1, 1, 0, 0,  6144));
        tbl.push_back(mk(    1,     1, 0, 1, 1, -6144));

        foreach (tbl[i]) begin
            do_pair(tbl[i].a, tbl[i].b, tbl[i].first, tbl[i].last, 0,
                    ov, z, bad);
            chk($sformatf("vec%0d_timing", i), bad, 0);
            chk($sformatf("vec%0d_out_valid", i), int'(ov),
                int'(tbl[i].ov));
            chk($sformatf("vec%0d_outZ", i), z, tbl[i].z);
        end
        @(posedge clk);
        #1;
        chk("pulse_one_cycle", int'(bus.out_valid), 0);

        // in_valid held high for 20 cycles
        @(negedge clk);
        bus.inA      = 14'(7);
        bus.inB      = 14'(7);
        bus.in_first = 1'b1;
        bus.in_last  = 1'b1;
        bus.in_valid = 1'b1;
        pat     = 0;
        exp_pat = 0;
        acc_n   = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.in_ready === 1'b1) begin
                pat   = pat | (1 << c);
                acc_n = acc_n + 1;
            end
            if (c % 5 == 0) exp_pat = exp_pat | (1 << c);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("hold_ready_pattern", pat, exp_pat);
        chk("hold_accept_count", acc_n, 4);
        repeat (6) @(posedge clk);
        #1;
        chk("hold_outZ", int'(bus.outZ), 49);

        // Reset two cycles after a last-pair acceptance
        @(negedge clk);
        bus.inA      = 14'(9);
        bus.inB      = 14'(9);
        bus.in_first = 1'b1;
        bus.in_last  = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        pulses = 0;
        repeat (2) begin
            @(posedge clk);
            #1 pulses = pulses + int'(bus.out_valid === 1'b1);
        end
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", int'(bus.in_ready), 1);
        chk("midrst_outZ", int'(bus.outZ), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1 pulses = pulses + int'(bus.out_valid === 1'b1);
        end
        chk("midrst_no_pulse", pulses, 0);
        chk("midrst_release_ready", int'(bus.in_ready), 1);
        chk("midrst_release_outZ", int'(bus.outZ), 0);

        // Random frames against the modular model
        sum = 0;
        for (int fr = 0; fr < NFRAMES; fr++) begin
            int len;
            len = int'($urandom_range(1, 16));
            for (int j = 0; j < len; j++) begin
                int a;
                int b;
                int gap;
                bit f;
                bit l;
                a   = rnd_op();
                b   = rnd_op();
                f   = (j == 0);
                l   = (j == len - 1);
                gap = ($urandom_range(0, 7) == 0) ? 1 : 0;
                if (f) sum = longint'(a) * longint'(b);
                else   sum = sum + longint'(a) * longint'(b);
                do_pair(a, b, f, l, gap, ov, z, bad);
                chk($sformatf("rnd%0d_%0d_timing", fr, j), bad, 0);
                chk($sformatf("rnd%0d_%0d_out_valid", fr, j), int'(ov),
                    int'(l));
                chk($sformatf("rnd%0d_%0d_outZ", fr, j), z, cmod(sum));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
